// File: rtl/dff_en_pipe.sv
// Enabled, synchronously clearable register pipeline of DEPTH stages, WIDTH bits each.
// Latency is DEPTH enabled edges; en=0 freezes every stage. There is no backpressure.
module dff_en_pipe #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d,
  input  logic                   en,
  input  logic                   clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH*DEPTH-1:0] taps
);

  if (WIDTH < 1 || DEPTH < 1 || DEPTH > 64) begin : g_bad_param
    $fatal(1, "dff_en_pipe: WIDTH must be >= 1 and DEPTH must be in 1..64");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  // clr outranks en, so a cleared edge never captures d
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VALUE;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VALUE;
    end else if (en) begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*WIDTH +: WIDTH] = stage[k];
  end

  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_dff_en_pipe.sv
// Scoreboard bench for dff_en_pipe: three configurations driven by directed vectors.
module tb_dff_en_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration
  logic r1, d1, en1, clr1, q1, taps1;
  // WIDTH=8, DEPTH=3
  logic       r3, en3, clr3;
  logic [7:0] d3, q3;
  logic [23:0] taps3;
  // WIDTH=8, DEPTH=2, RESET_VALUE=0xA5
  logic       r2, en2, clr2;
  logic [7:0] d2, q2;
  logic [15:0] taps2;

  dff_en_pipe u1 (
    .clk(clk), .reset(r1), .d(d1), .en(en1), .clr(clr1), .q(q1), .taps(taps1)
  );

  dff_en_pipe #(.WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .reset(r3), .d(d3), .en(en3), .clr(clr3), .q(q3), .taps(taps3)
  );

  dff_en_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'hA5)) u2 (
    .clk(clk), .reset(r2), .d(d2), .en(en2), .clr(clr2), .q(q2), .taps(taps2)
  );

  typedef struct {
    int          id;
    logic [23:0] q;
    logic [23:0] taps;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event async_ev;

  // Monitor: one sample point 1 time unit after every clock edge or asynchronous probe
  initial begin
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (sb.size() > 0) begin
        exp_t        e;
        logic [23:0] aq;
        logic [23:0] at;
        e  = sb.pop_front();
        aq = '0;
        at = '0;
        case (e.id)
          1: begin aq = {23'd0, q1}; at = {23'd0, taps1}; end
          3: begin aq = {16'd0, q3}; at = taps3;          end
          default: begin aq = {16'd0, q2}; at = {8'd0, taps2}; end
        endcase
        checks++;
        if (aq !== e.q || at !== e.taps) begin
          failures++;
          $display("FAIL %s: got q=%h taps=%h, expected q=%h taps=%h",
                   e.name, aq, at, e.q, e.taps);
        end
      end
    end
  end

  task automatic push(input int id, input logic [23:0] eq, input logic [23:0] et,
                      input string nm);
    exp_t e;
    e.id = id; e.q = eq; e.taps = et; e.name = nm;
    sb.push_back(e);
  endtask

  // Expect the current (between-edge) outputs without waiting for a clock
  task automatic check_now(input int id, input logic [23:0] eq, input logic [23:0] et,
                           input string nm);
    push(id, eq, et, nm);
    -> async_ev;
    #2;
  endtask

  // Drive one cycle at the negedge; expectation is the state after the next rising edge
  task automatic cyc(input int id, input logic [7:0] dv, input logic env, input logic clrv,
                     input logic [23:0] eq, input logic [23:0] et, input string nm);
    case (id)
      1: begin d1 = dv[0]; en1 = env; clr1 = clrv; end
      3: begin d3 = dv;    en3 = env; clr3 = clrv; end
      default: begin d2 = dv; en2 = env; clr2 = clrv; end
    endcase
    push(id, eq, et, nm);
    @(negedge clk);
  endtask

  initial begin
    r1 = 1'b1; d1 = 1'b0; en1 = 1'b1; clr1 = 1'b0;
    r3 = 1'b1; d3 = 8'h00; en3 = 1'b1; clr3 = 1'b0;
    r2 = 1'b1; d2 = 8'h00; en2 = 1'b1; clr2 = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_now(1, 24'h0, 24'h0, "rst_u1");
    check_now(3, 24'h0, 24'h0, "rst_u3");
    check_now(2, 24'hA5, 24'hA5A5, "rst_u2");

    // single DFF follows d one clock late
    @(negedge clk);
    r1 = 1'b0;
    check_now(1, 24'h0, 24'h0, "u1_release");
    @(negedge clk);
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h1, 24'h1, "u1_d1");
    cyc(1, 8'h0, 1'b1, 1'b0, 24'h0, 24'h0, "u1_d0");
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h1, 24'h1, "u1_d1b");
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h1, 24'h1, "u1_d1c");
    cyc(1, 8'h0, 1'b1, 1'b0, 24'h0, 24'h0, "u1_d0b");
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h1, 24'h1, "u1_load1");
    // asynchronous reset between edges
    #2;
    r1 = 1'b1;
    check_now(1, 24'h0, 24'h0, "u1_async_rst");
    @(negedge clk);
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h0, 24'h0, "u1_rst_hold");
    r1 = 1'b0;
    cyc(1, 8'h1, 1'b1, 1'b0, 24'h1, 24'h1, "u1_after_rst");

    // three-stage byte pipeline, with an en=0 gap
    r3 = 1'b0;
    cyc(3, 8'h11, 1'b1, 1'b0, 24'h00, 24'h000011, "u3_e1");
    cyc(3, 8'h22, 1'b1, 1'b0, 24'h00, 24'h001122, "u3_e2");
    cyc(3, 8'h33, 1'b1, 1'b0, 24'h11, 24'h112233, "u3_e3");
    cyc(3, 8'h44, 1'b1, 1'b0, 24'h22, 24'h223344, "u3_e4");
    cyc(3, 8'h55, 1'b0, 1'b0, 24'h22, 24'h223344, "u3_hold1");
    cyc(3, 8'h66, 1'b0, 1'b0, 24'h22, 24'h223344, "u3_hold2");
    cyc(3, 8'h77, 1'b1, 1'b0, 24'h33, 24'h334477, "u3_resume1");
    cyc(3, 8'h88, 1'b1, 1'b0, 24'h44, 24'h447788, "u3_resume2");
    cyc(3, 8'h99, 1'b1, 1'b0, 24'h77, 24'h778899, "u3_resume3");

    // two-stage pipeline with non-zero reset value
    r2 = 1'b0;
    cyc(2, 8'h01, 1'b1, 1'b0, 24'hA5, 24'hA501, "u2_e1");
    cyc(2, 8'h02, 1'b1, 1'b0, 24'h01, 24'h0102, "u2_e2");
    cyc(2, 8'h03, 1'b1, 1'b1, 24'hA5, 24'hA5A5, "u2_clr_en");
    cyc(2, 8'h04, 1'b1, 1'b0, 24'hA5, 24'hA504, "u2_post_clr1");
    cyc(2, 8'h05, 1'b1, 1'b0, 24'h04, 24'h0405, "u2_post_clr2");
    #2;
    r2 = 1'b1;
    check_now(2, 24'hA5, 24'hA5A5, "u2_async_rst");
    @(negedge clk);
    cyc(2, 8'h06, 1'b1, 1'b0, 24'hA5, 24'hA5A5, "u2_rst_hold");
    r2 = 1'b0;
    cyc(2, 8'h07, 1'b1, 1'b0, 24'hA5, 24'hA507, "u2_rel1");
    cyc(2, 8'h08, 1'b1, 1'b0, 24'h07, 24'h0708, "u2_rel2");
    cyc(2, 8'h09, 1'b1, 1'b0, 24'h08, 24'h0809, "u2_rel3");
    cyc(2, 8'h0A, 1'b0, 1'b1, 24'hA5, 24'hA5A5, "u2_clr_no_en");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dff_en_pipe.md
Name: dff_en_pipe

Overview:
- Parameterizable registered delay element: D flip-flop bank with clock enable, synchronous clear and configurable pipeline depth.
- Default configuration (WIDTH=1, DEPTH=1) is a single enabled DFF.
- Used in the interleaver datapath to retime control strobes by one clock, e.g. delaying the RAM write enable so it lines up with the counter address.
- Enable is tied high in that use.

Parameters:
- WIDTH, 1: bit width of d, q and each pipeline stage.
- DEPTH, 1: number of register stages (clock cycles of latency). Legal range 1..64.
- RESET_VALUE, 0 (WIDTH bits): value loaded into every stage on reset and on clr.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  data in.
- en  input  1  clock enable; 1 = pipeline advances this edge, 0 = all stages hold.
- clr  input  1  synchronous clear, active-high.
- q  output  WIDTH  last stage contents (stage DEPTH-1).
- taps  output  WIDTH*DEPTH  all stage contents concatenated; stage 0 in bits [WIDTH-1:0], stage k in bits [(k+1)*WIDTH-1 : k*WIDTH].

Behaviour:
- Storage: DEPTH registers stage[0..DEPTH-1], each WIDTH bits.
- Reset:
  - reset=1 forces every stage to RESET_VALUE immediately, independent of clk. q and taps follow combinationally.
  - Holds while reset is high.
  - On reset release, the first rising clk edge with reset=0 performs a normal update.
- Priority at each rising clk edge (reset low): clr over en.
  - clr=1: every stage <= RESET_VALUE, regardless of en.
  - clr=0, en=1: stage[0] <= d; stage[k] <= stage[k-1] for k=1..DEPTH-1.
  - clr=0, en=0: all stages hold.
- Latency:
  - With en held at 1, q at the edge N+DEPTH-1 (i.e. after DEPTH rising edges) equals d sampled at edge N.
  - With DEPTH=1, q is d delayed by exactly one clock.
- en gating: cycles with en=0 do not count toward latency. Data advances one stage per enabled edge only.
- Output timing: q and taps are pure register outputs, with no combinational path from d, en or clr.
- Reset mid-operation: all in-flight data is discarded. After release, q shows RESET_VALUE until new data has propagated DEPTH enabled edges.
- Simultaneous clr and en: clr wins; d is not captured on that edge.
- Width: no arithmetic. Data bits pass through unmodified and bits never mix across WIDTH lanes.
- X-handling: an X on d propagates only through enabled stages. Reset and clr always produce a clean RESET_VALUE.
- Elaboration: DEPTH<1 or WIDTH<1 must cause a fatal elaboration error.

Test Plan:
- Default params, en=1, clr=0; reset high, then released. Drive d=1,0,1,1,0 on successive edges -> q=0 until the first edge, then q follows d delayed exactly one cycle (1,0,1,1,0).
- Default params; q=1 stored; assert reset asynchronously between clock edges -> q=0 immediately, before any clk edge. Q stays 0 while reset is high.
- WIDTH=8, DEPTH=3, en=1; d=0x11,0x22,0x33,0x44 -> q=0x11 at the third edge after 0x11 is applied. taps at that point = {0x11,0x22,0x33}, with stage0=0x33.
- WIDTH=8, DEPTH=3; drop en to 0 for 2 cycles mid-stream with d changing -> q and taps frozen for those cycles. Sequence resumes with no lost or duplicated values, and d values presented while en=0 are never captured.
- WIDTH=8, DEPTH=2, RESET_VALUE=0xA5; assert clr=1 with en=1 for one edge -> all taps = 0xA5 after that edge. d on that edge is discarded.
- DEPTH=2; pulse reset mid-stream -> all stages RESET_VALUE. After release, q=RESET_VALUE for 2 enabled edges, then new data appears.
